// File: rtl/mul_repeated_add.sv
// Purpose: unsigned multiplier, P = A * B built from B successive additions of A.
// Latency: A at t0+1, B at t0+2, done rises after edge t0+3+B (start sampled at t0).
// Backpressure: none; host holds start to stay in DONE, drops it for >=1 cycle to re-arm.
module mul_repeated_add #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] product,
  output logic             done,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    MULT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;

  logic ld_a;
  logic ld_b;
  logic ld_p;
  logic clr_p;
  logic dec_b;
  logic eqz;

  // B==0 detector; ends the MULT loop and suppresses the final add/decrement
  assign eqz     = (b_q == '0);
  assign product = p_q;

  // Datapath strobes decode from the current state only
  always_comb begin
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    ld_p  = 1'b0;
    clr_p = 1'b0;
    dec_b = 1'b0;
    case (state)
      LOAD_A: ld_a = 1'b1;
      LOAD_B: begin
        ld_b  = 1'b1;
        clr_p = 1'b1;
      end
      MULT: begin
        ld_p  = 1'b1;
        dec_b = 1'b1;
      end
      default: ;
    endcase
  end

  // Moore control FSM with registered done/busy so outputs are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_A;
            busy  <= 1'b1;
          end
        end
        LOAD_A: state <= LOAD_B;
        LOAD_B: state <= MULT;
        MULT: begin
          if (eqz) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Operand and accumulator registers; adder wraps modulo 2^WIDTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      if (ld_a) begin
        a_q <= data_in;
      end
      if (ld_b) begin
        b_q <= data_in;
      end else if (dec_b && !eqz) begin
        b_q <= b_q - 1'b1;
      end
      if (clr_p) begin
        p_q <= '0;
      end else if (ld_p && !eqz) begin
        p_q <= p_q + a_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_repeated_add.sv
// Directed bench for mul_repeated_add: operand loading, zero operands, wraparound,
// async abort mid-multiply, and the start/done handshake.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mul_repeated_add;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] product;
  logic             done;
  logic             busy;

  int tests;
  int fails;

  mul_repeated_add #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation from IDLE and wait (bounded) for done.
  // Edges counted after B is loaded until done is seen should be B+2.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    int n;
    start = 1'b1;
    @(posedge clk);                 // t0: start sampled in IDLE
    @(negedge clk);
    data_in = a;
    check({tag, "_busy_load"}, {31'd0, busy}, 32'd1);
    @(posedge clk);                 // t0+1: A captured
    @(negedge clk);
    data_in = b;
    n = 0;
    while (!done && n < 1000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      data_in = WIDTH'($urandom);  // must not disturb the result
    end
    check({tag, "_cycles"}, n, 32'(b) + 32'd2);
    check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  // Drop start for one cycle in DONE so the FSM returns to IDLE
  task automatic go_idle(input string tag);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1. Basic, with start held high through DONE
    run_op("basic", 16'd17, 16'd5, 16'd85);
    repeat (3) @(negedge clk);
    check("basic_hold_done", {31'd0, done}, 32'd1);
    check("basic_hold_product", {16'd0, product}, 32'd85);
    go_idle("basic");

    // 2. Zero operands
    run_op("b_zero", 16'd9, 16'd0, 16'd0);
    go_idle("b_zero");
    run_op("a_zero", 16'd0, 16'd7, 16'd0);
    go_idle("a_zero");

    // 3. Overflow wraps modulo 2^16
    run_op("ovf_4096x16", 16'h1000, 16'd16, 16'h0000);
    go_idle("ovf1");
    run_op("ovf_300x300", 16'd300, 16'd300, 16'd24464);
    go_idle("ovf2");

    // 4. Async reset after two additions of 17*5
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd17;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd5;
    @(posedge clk);                 // B loaded, P cleared
    @(posedge clk);                 // P = 17
    @(posedge clk);                 // P = 34
    @(negedge clk);
    check("abort_running_sum", {16'd0, product}, 32'd34);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_product", {16'd0, product}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_stays_idle", {31'd0, busy}, 32'd0);
    run_op("after_abort_6x7", 16'd6, 16'd7, 16'd42);

    // 5. Handshake: release to IDLE, then a fresh operation
    go_idle("hs");
    run_op("hs_3x4", 16'd3, 16'd4, 16'd12);
    go_idle("hs_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
